// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared state encoding and bus constants for the I2C master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WDATA    = 4'd4,
        WACK     = 4'd5,
        RDATA    = 4'd6,
        MACK     = 4'd7,
        STOP     = 4'd8
    } i2c_state_t;

    localparam logic I2C_RW_WRITE     = 1'b0;
    localparam logic I2C_RW_READ      = 1'b1;
    localparam int   I2C_BITS_PER_TXN = 20;

endpackage

`default_nettype wire

// File: rtl/i2c_clk_gen.sv
// ============================================================================
// Module      : i2c_clk_gen
// Description : Quarter-period counter and 2-bit quarter index for SCL timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_clk_gen #(
    parameter int QUARTER = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       q_tick,
    output logic [1:0] q_idx
);

    localparam int            CW     = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(QUARTER - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;

    // Counter and index sit at zero whenever the master is idle.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign q_tick = en && (r_cnt == C_LAST);
    assign q_idx  = r_idx;

endmodule

`default_nettype wire

// File: rtl/i2c_master.sv
// ============================================================================
// Module      : i2c_master
// Description : Single-byte I2C master: START, address+R/W, one data byte, STOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_master
    import i2c_pkg::*;
#(
    parameter int QUARTER = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    input  logic       sda_i,
    output logic       scl,
    output logic       sda_oe,
    output logic [7:0] datard,
    output logic       done,
    output logic       busy,
    output logic       ack_err
);

    i2c_state_t r_state;
    i2c_state_t w_state_nxt;

    logic       w_tick;
    logic [1:0] w_qidx;
    logic       w_bit_end;
    logic       w_sample;
    logic       w_last_bit;
    logic       w_scl;
    logic       w_sda_oe;

    logic [2:0] r_bitcnt;
    logic [7:0] r_tx;
    logic [7:0] r_din;
    logic [7:0] r_rx;
    logic [7:0] r_datard;
    logic       r_wr;
    logic       r_sda_s;
    logic       r_done;
    logic       r_ack_err;

    i2c_clk_gen #(
        .QUARTER (QUARTER)
    ) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (r_state != IDLE),
        .q_tick (w_tick),
        .q_idx  (w_qidx)
    );

    assign w_bit_end  = w_tick && (w_qidx == 2'd3);
    assign w_sample   = w_tick && (w_qidx == 2'd2);
    assign w_last_bit = (r_bitcnt == 3'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus levels are decoded purely from registered state and quarter index.
    always_comb begin
        w_state_nxt = r_state;
        w_scl       = 1'b1;
        w_sda_oe    = 1'b0;
        case (r_state)
            IDLE: begin
                if (newd) w_state_nxt = START;
            end
            START: begin
                w_sda_oe = w_qidx[1];
                if (w_bit_end) w_state_nxt = ADDR;
            end
            ADDR: begin
                w_scl    = w_qidx[1];
                w_sda_oe = ~r_tx[7];
                if (w_bit_end && w_last_bit) w_state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                w_scl = w_qidx[1];
                if (w_bit_end) begin
                    if (r_sda_s)   w_state_nxt = STOP;
                    else if (r_wr) w_state_nxt = WDATA;
                    else           w_state_nxt = RDATA;
                end
            end
            WDATA: begin
                w_scl    = w_qidx[1];
                w_sda_oe = ~r_tx[7];
                if (w_bit_end && w_last_bit) w_state_nxt = WACK;
            end
            WACK: begin
                w_scl = w_qidx[1];
                if (w_bit_end) w_state_nxt = STOP;
            end
            RDATA: begin
                w_scl = w_qidx[1];
                if (w_bit_end && w_last_bit) w_state_nxt = MACK;
            end
            MACK: begin
                w_scl = w_qidx[1];
                if (w_bit_end) w_state_nxt = STOP;
            end
            STOP: begin
                w_scl    = (w_qidx != 2'd0);
                w_sda_oe = ~w_qidx[1];
                if (w_bit_end) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bitcnt  <= 3'd0;
            r_tx      <= 8'h00;
            r_din     <= 8'h00;
            r_rx      <= 8'h00;
            r_datard  <= 8'h00;
            r_wr      <= 1'b0;
            r_sda_s   <= 1'b1;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_sample) r_sda_s <= sda_i;
            case (r_state)
                IDLE: begin
                    if (newd) begin
                        r_wr      <= wr;
                        r_tx      <= {addr, (wr ? I2C_RW_WRITE : I2C_RW_READ)};
                        r_din     <= din;
                        r_bitcnt  <= 3'd7;
                        r_ack_err <= 1'b0;
                    end
                end
                ADDR, WDATA: begin
                    if (w_bit_end) begin
                        r_tx     <= {r_tx[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt - 3'd1;
                    end
                end
                ADDR_ACK: begin
                    if (w_bit_end) begin
                        if (r_sda_s) r_ack_err <= 1'b1;
                        r_tx     <= r_din;
                        r_bitcnt <= 3'd7;
                    end
                end
                WACK: begin
                    if (w_bit_end && r_sda_s) r_ack_err <= 1'b1;
                end
                RDATA: begin
                    if (w_sample)  r_rx     <= {r_rx[6:0], sda_i};
                    if (w_bit_end) r_bitcnt <= r_bitcnt - 3'd1;
                end
                MACK: begin
                    if (w_bit_end) r_datard <= r_rx;
                end
                STOP: begin
                    if (w_bit_end) r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign scl     = w_scl;
    assign sda_oe  = w_sda_oe;
    assign datard  = r_datard;
    assign done    = r_done;
    assign busy    = (r_state != IDLE);
    assign ack_err = r_ack_err;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master.sv
// ============================================================================
// Module      : tb_i2c_master
// Description : Randomized scoreboard bench with a behavioural I2C slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_master;

    localparam int         Q        = 3;
    localparam logic [6:0] SLV_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       newd;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] din;
    logic       sda_i;
    logic       scl;
    logic       sda_oe;
    logic [7:0] datard;
    logic       done;
    logic       busy;
    logic       ack_err;

    logic       slv_pull = 1'b0;
    logic       sda_bus;
    logic [7:0] slv_rdata = 8'h00;
    logic       slv_data_nack = 1'b0;

    always #5 clk = ~clk;

    assign sda_bus = ~(sda_oe | slv_pull);
    assign sda_i   = sda_bus;

    i2c_master #(.QUARTER(Q)) dut (
        .clk     (clk),
        .rst     (rst),
        .newd    (newd),
        .wr      (wr),
        .addr    (addr),
        .din     (din),
        .sda_i   (sda_i),
        .scl     (scl),
        .sda_oe  (sda_oe),
        .datard  (datard),
        .done    (done),
        .busy    (busy),
        .ack_err (ack_err)
    );

    typedef struct {
        logic [8:0] f0;
        logic [8:0] f1;
        int         nframes;
        logic       ack_err;
        logic [7:0] datard;
        int         done_cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [7:0] m_datard = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Bus monitor and slave, sampled on the falling clk edge.
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         nbits = 0;
    logic [8:0] fsh = 9'h0;
    logic [8:0] frames[$];
    logic       saw_start = 1'b0;
    logic       saw_stop  = 1'b0;

    task automatic slave_drive();
        logic rd, acked;
        rd    = (frames.size() > 0) ? frames[0][1] : 1'b0;
        acked = (frames.size() > 0) ? ~frames[0][0] : 1'b0;
        slv_pull = 1'b0;
        if (nbits == 8)
            slv_pull = (fsh[7:1] == SLV_ADDR);
        else if (nbits >= 9 && nbits <= 16 && rd && acked)
            slv_pull = ~slv_rdata[16 - nbits];
        else if (nbits == 17 && !rd && acked)
            slv_pull = ~slv_data_nack;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            slv_pull = 1'b0;
            nbits    = 0;
            frames.delete();
        end else begin
            if (scl && prev_scl && prev_sda && !sda_bus) begin
                saw_start = 1'b1;
                saw_stop  = 1'b0;
                nbits     = 0;
                frames.delete();
                slv_pull  = 1'b0;
            end else if (scl && prev_scl && !prev_sda && sda_bus) begin
                saw_stop = 1'b1;
            end else if (scl && !prev_scl) begin
                fsh = {fsh[7:0], sda_bus};
                nbits++;
                if (nbits % 9 == 0) frames.push_back(fsh);
            end else if (!scl && prev_scl) begin
                slave_drive();
            end
            if (done) begin
                check("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("done_latency", cyc, e.done_cyc);
                    check("saw_start", saw_start, 1);
                    check("saw_stop", saw_stop, 1);
                    check("nframes", frames.size(), e.nframes);
                    if (frames.size() > 0) check("addr_frame", frames[0], e.f0);
                    if (e.nframes > 1 && frames.size() > 1) check("data_frame", frames[1], e.f1);
                    check("ack_err", ack_err, e.ack_err);
                    check("datard", datard, e.datard);
                    check("busy_at_done", busy, 0);
                end
                saw_start = 1'b0;
                saw_stop  = 1'b0;
                nbits     = 0;
            end
        end
        prev_scl = scl;
        prev_sda = sda_bus;
    end

    // Issue one request at a negedge and push the model's expected outcome.
    task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d,
                         input logic [7:0] rdata, input logic dnack);
        exp_t e;
        logic ack;
        slv_rdata     = rdata;
        slv_data_nack = dnack;
        wr   = w;
        addr = a;
        din  = d;
        newd = 1'b1;
        ack  = (a == SLV_ADDR);
        e.f0 = {a, ~w, ~ack};
        e.f1 = 9'h0;
        if (!ack) begin
            e.nframes  = 1;
            e.ack_err  = 1'b1;
            e.datard   = m_datard;
            e.done_cyc = cyc + 1 + 44 * Q;
        end else if (w) begin
            e.nframes  = 2;
            e.f1       = {d, dnack};
            e.ack_err  = dnack;
            e.datard   = m_datard;
            e.done_cyc = cyc + 1 + 80 * Q;
        end else begin
            e.nframes  = 2;
            e.f1       = {rdata, 1'b1};
            e.ack_err  = 1'b0;
            e.datard   = rdata;
            m_datard   = rdata;
            e.done_cyc = cyc + 1 + 80 * Q;
        end
        sb.push_back(e);
        @(negedge clk);
        newd = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (sb.size() != 0 && k < 120 * Q) begin
            @(negedge clk);
            k++;
        end
        check("completed_in_budget", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst  = 1'b0;
        newd = 1'b0;
        wr   = 1'b0;
        addr = 7'h00;
        din  = 8'h00;
        @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_datard", datard, 8'h00);
        check("rst_ack_err", ack_err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        issue(1'b1, 7'h50, 8'hA5, 8'h00, 1'b0); wait_done();
        issue(1'b0, 7'h50, 8'h00, 8'h3C, 1'b0); wait_done();
        issue(1'b1, 7'h11, 8'h5A, 8'h00, 1'b0); wait_done();
        issue(1'b1, 7'h50, 8'hC3, 8'h00, 1'b1); wait_done();

        // Request strobe while busy must be ignored.
        issue(1'b1, 7'h50, 8'h96, 8'h00, 1'b0);
        repeat (30 * Q) @(negedge clk);
        wr = 1'b0; addr = 7'h7F; din = 8'hFF; newd = 1'b1;
        @(negedge clk);
        newd = 1'b0;
        wait_done();
        repeat (4 * Q) @(negedge clk);
        check("no_stray_busy", busy, 0);

        // Abort by reset during data bit 3.
        issue(1'b0, 7'h50, 8'h00, 8'hE7, 1'b0);
        k = 0;
        while (nbits < 13 && k < 120 * Q) begin
            @(negedge clk);
            k++;
        end
        check("reached_data_bit3", nbits >= 13, 1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_scl", scl, 1);
        check("abort_sda_oe", sda_oe, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        sb.delete();
        m_datard = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        issue(1'b0, 7'h50, 8'h00, 8'h81, 1'b0); wait_done();

        for (int i = 0; i < 14; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) != 0) ? SLV_ADDR : 7'($urandom);
            issue(1'($urandom_range(0, 1)), a, 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0));
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
